// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding / hazard controller:
// operand-select encodings and default datapath widths.
package hazard_fwd_ctrl_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int DEFAULT_AW   = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline-side bundle of the forwarding / hazard controller; the controller
// takes the slave view, the surrounding pipeline (or a bench) the master view.
interface hazard_fwd_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2,
  parameter int CNT_W = 32
) ();

  logic                 id_valid_i;
  logic [NRD*AW-1:0]    id_rs_addr_i;
  logic [NRD-1:0]       id_rs_used_i;
  logic [AW-1:0]        id_rd_addr_i;
  logic                 id_rd_wena_i;
  logic                 id_is_md_i;
  logic                 flush_i;
  logic [AW-1:0]        id_ex_rd_addr_i;
  logic                 id_ex_rd_wena_i;
  logic                 id_ex_is_load_i;
  logic [NRD*AW-1:0]    ex_rs_addr_i;
  logic [NRD*XLEN-1:0]  ex_rs_data_i;
  logic [AW-1:0]        ex_mem_rd_addr_i;
  logic                 ex_mem_rd_wena_i;
  logic [XLEN-1:0]      ex_mem_data_i;
  logic [AW-1:0]        mem_wb_rd_addr_i;
  logic                 mem_wb_rd_wena_i;
  logic [XLEN-1:0]      mem_wb_data_i;
  logic [NRD*XLEN-1:0]  ex_rs_data_o;
  logic [NRD*2-1:0]     fwd_sel_o;
  logic                 stall_o;
  logic                 md_busy_o;
  logic                 md_done_o;
  logic [AW-1:0]        md_rd_o;
  logic [CNT_W-1:0]     stall_cnt_o;

  modport slave (
    input  id_valid_i, id_rs_addr_i, id_rs_used_i, id_rd_addr_i, id_rd_wena_i,
           id_is_md_i, flush_i, id_ex_rd_addr_i, id_ex_rd_wena_i, id_ex_is_load_i,
           ex_rs_addr_i, ex_rs_data_i, ex_mem_rd_addr_i, ex_mem_rd_wena_i,
           ex_mem_data_i, mem_wb_rd_addr_i, mem_wb_rd_wena_i, mem_wb_data_i,
    output ex_rs_data_o, fwd_sel_o, stall_o, md_busy_o, md_done_o, md_rd_o,
           stall_cnt_o
  );

  modport master (
    output id_valid_i, id_rs_addr_i, id_rs_used_i, id_rd_addr_i, id_rd_wena_i,
           id_is_md_i, flush_i, id_ex_rd_addr_i, id_ex_rd_wena_i, id_ex_is_load_i,
           ex_rs_addr_i, ex_rs_data_i, ex_mem_rd_addr_i, ex_mem_rd_wena_i,
           ex_mem_data_i, mem_wb_rd_addr_i, mem_wb_rd_wena_i, mem_wb_data_i,
    input  ex_rs_data_o, fwd_sel_o, stall_o, md_busy_o, md_done_o, md_rd_o,
           stall_cnt_o
  );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_mux_port.sv
// One EX source-operand port: picks the youngest in-flight producer of rs
// (EX/MEM before MEM/WB, never x0) and muxes the matching data word.
module fwd_mux_port
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter int AW   = DEFAULT_AW
) (
  input  logic            fwd_en,
  input  logic [AW-1:0]   rs_addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [AW-1:0]   ex_mem_rd_addr,
  input  logic            ex_mem_rd_wena,
  input  logic [XLEN-1:0] ex_mem_data,
  input  logic [AW-1:0]   mem_wb_rd_addr,
  input  logic            mem_wb_rd_wena,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic [1:0]      fwd_sel,
  output logic [XLEN-1:0] operand
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (fwd_en) begin
      if (ex_mem_rd_wena && (ex_mem_rd_addr != '0) && (ex_mem_rd_addr == rs_addr))
        sel = FWD_EXMEM;
      else if (mem_wb_rd_wena && (mem_wb_rd_addr != '0) && (mem_wb_rd_addr == rs_addr))
        sel = FWD_MEMWB;
    end
  end

  always_comb begin
    operand = rs_data;
    case (sel)
      FWD_EXMEM: operand = ex_mem_data;
      FWD_MEMWB: operand = mem_wb_data;
      default:   operand = rs_data;
    endcase
  end

  assign fwd_sel = sel;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// EX-stage forwarding and hazard control: per-port operand forwarding,
// load-use and mul/div scoreboard stalls, and a saturating stall counter.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int XLEN   = DEFAULT_XLEN,
  parameter int AW     = DEFAULT_AW,
  parameter int NRD    = 2,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input logic              clk,
  input logic              rst,
  hazard_fwd_ctrl_if.slave bus
);

  localparam int MDC_W = $clog2(MD_LAT + 1);

  logic [MDC_W-1:0]    md_cnt;
  logic [AW-1:0]       md_rd;
  logic [CNT_W-1:0]    stall_cnt;
  logic [NRD*2-1:0]    fwd_sel;
  logic [NRD*XLEN-1:0] fwd_data;
  logic [NRD-1:0]      lu_hit;
  logic [NRD-1:0]      raw_hit;
  logic                md_busy;
  logic                md_done;
  logic                load_use;
  logic                md_hazard;
  logic                stall;
  logic                md_issue;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_mux_port #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_port (
      .fwd_en         (!rst),
      .rs_addr        (bus.ex_rs_addr_i[p*AW +: AW]),
      .rs_data        (bus.ex_rs_data_i[p*XLEN +: XLEN]),
      .ex_mem_rd_addr (bus.ex_mem_rd_addr_i),
      .ex_mem_rd_wena (bus.ex_mem_rd_wena_i),
      .ex_mem_data    (bus.ex_mem_data_i),
      .mem_wb_rd_addr (bus.mem_wb_rd_addr_i),
      .mem_wb_rd_wena (bus.mem_wb_rd_wena_i),
      .mem_wb_data    (bus.mem_wb_data_i),
      .fwd_sel        (fwd_sel[p*2 +: 2]),
      .operand        (fwd_data[p*XLEN +: XLEN])
    );

    assign lu_hit[p]  = bus.id_rs_used_i[p] && (bus.id_rs_addr_i[p*AW +: AW] == bus.id_ex_rd_addr_i);
    assign raw_hit[p] = bus.id_rs_used_i[p] && (bus.id_rs_addr_i[p*AW +: AW] == md_rd);
  end

  // The countdown doubles as the scoreboard: non-zero means an MD result is
  // still pending, and the final count marks its write-back cycle.
  assign md_busy = (md_cnt != '0);
  assign md_done = (md_cnt == MDC_W'(1));

  assign load_use  = bus.id_ex_is_load_i && bus.id_ex_rd_wena_i &&
                     (bus.id_ex_rd_addr_i != '0) && (|lu_hit);
  assign md_hazard = md_busy &&
                     (((md_rd != '0) && ((|raw_hit) ||
                       (bus.id_rd_wena_i && (bus.id_rd_addr_i == md_rd)))) ||
                      bus.id_is_md_i);
  assign stall     = !rst && bus.id_valid_i && (load_use || md_hazard);
  assign md_issue  = bus.id_valid_i && bus.id_is_md_i && !stall && !bus.flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt    <= '0;
      md_rd     <= '0;
      stall_cnt <= '0;
    end else begin
      if (md_issue) begin
        md_cnt <= MDC_W'(MD_LAT);
        md_rd  <= bus.id_rd_wena_i ? bus.id_rd_addr_i : '0;
      end else if (md_busy) begin
        md_cnt <= md_cnt - MDC_W'(1);
      end
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.ex_rs_data_o = fwd_data;
  assign bus.fwd_sel_o    = fwd_sel;
  assign bus.stall_o      = stall;
  assign bus.md_busy_o    = md_busy;
  assign bus.md_done_o    = md_done;
  assign bus.md_rd_o      = md_rd;
  assign bus.stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: a forwarding/load-use vector table
// followed by hand-written multi-cycle mul/div, reset and saturation sequences.
module tb_hazard_fwd_ctrl;

  localparam int XLEN   = 32;
  localparam int AW     = 5;
  localparam int NRD    = 2;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  localparam logic [63:0] RF_A = 64'h1111_6666_1111_5555;
  localparam logic [63:0] RF_B = 64'h1234_5678_9ABC_DEF0;

  typedef struct {
    logic [9:0]  ex_rs_addr;
    logic [63:0] ex_rs_data;
    logic [4:0]  exm_rd;
    logic        exm_we;
    logic [31:0] exm_data;
    logic [4:0]  mwb_rd;
    logic        mwb_we;
    logic [31:0] mwb_data;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_used;
    logic [4:0]  idex_rd;
    logic        idex_we;
    logic        idex_ld;
    logic [3:0]  exp_sel;
    logic [63:0] exp_data;
    logic        exp_stall;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vectors;
  int   n_miscompares;
  vec_t vecs[13];

  hazard_fwd_ctrl_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .CNT_W(CNT_W)) bus ();

  hazard_fwd_ctrl #(
    .XLEN   (XLEN),
    .AW     (AW),
    .NRD    (NRD),
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic drive_idle();
    bus.id_valid_i       = 1'b0;
    bus.id_rs_addr_i     = '0;
    bus.id_rs_used_i     = '0;
    bus.id_rd_addr_i     = '0;
    bus.id_rd_wena_i     = 1'b0;
    bus.id_is_md_i       = 1'b0;
    bus.flush_i          = 1'b0;
    bus.id_ex_rd_addr_i  = '0;
    bus.id_ex_rd_wena_i  = 1'b0;
    bus.id_ex_is_load_i  = 1'b0;
    bus.ex_rs_addr_i     = '0;
    bus.ex_rs_data_i     = RF_A;
    bus.ex_mem_rd_addr_i = '0;
    bus.ex_mem_rd_wena_i = 1'b0;
    bus.ex_mem_data_i    = '0;
    bus.mem_wb_rd_addr_i = '0;
    bus.mem_wb_rd_wena_i = 1'b0;
    bus.mem_wb_data_i    = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.ex_rs_addr_i     = v.ex_rs_addr;
    bus.ex_rs_data_i     = v.ex_rs_data;
    bus.ex_mem_rd_addr_i = v.exm_rd;
    bus.ex_mem_rd_wena_i = v.exm_we;
    bus.ex_mem_data_i    = v.exm_data;
    bus.mem_wb_rd_addr_i = v.mwb_rd;
    bus.mem_wb_rd_wena_i = v.mwb_we;
    bus.mem_wb_data_i    = v.mwb_data;
    bus.id_valid_i       = v.id_valid;
    bus.id_rs_addr_i     = v.id_rs;
    bus.id_rs_used_i     = v.id_used;
    bus.id_ex_rd_addr_i  = v.idex_rd;
    bus.id_ex_rd_wena_i  = v.idex_we;
    bus.id_ex_is_load_i  = v.idex_ld;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic check_md(input string tag, input logic busy, input logic done, input logic [4:0] rd);
    checkOutput({tag, " md_busy"}, 64'(bus.md_busy_o), 64'(busy));
    checkOutput({tag, " md_done"}, 64'(bus.md_done_o), 64'(done));
    checkOutput({tag, " md_rd"},   64'(bus.md_rd_o),   64'(rd));
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    rst = 1'b1;
    drive_idle();

    vecs[0]  = '{{5'd6,5'd5}, RF_A, 5'd5, 1'b1, 32'hAAAA, 5'd5, 1'b1, 32'hBBBB, 1'b0, 10'd0, 2'b00, 5'd0, 1'b0, 1'b0, 4'b0001, {32'h1111_6666, 32'h0000_AAAA}, 1'b0};
    vecs[1]  = '{{5'd6,5'd5}, RF_A, 5'd5, 1'b0, 32'hAAAA, 5'd5, 1'b1, 32'hBBBB, 1'b0, 10'd0, 2'b00, 5'd0, 1'b0, 1'b0, 4'b0010, {32'h1111_6666, 32'h0000_BBBB}, 1'b0};
    vecs[2]  = '{{5'd0,5'd9}, RF_B, 5'd0, 1'b1, 32'hDEAD, 5'd0, 1'b1, 32'hBEEF, 1'b0, 10'd0, 2'b00, 5'd0, 1'b0, 1'b0, 4'b0000, RF_B, 1'b0};
    vecs[3]  = '{{5'd8,5'd4}, RF_A, 5'd8, 1'b1, 32'hCCCC, 5'd4, 1'b1, 32'hDDDD, 1'b0, 10'd0, 2'b00, 5'd0, 1'b0, 1'b0, 4'b0110, {32'h0000_CCCC, 32'h0000_DDDD}, 1'b0};
    vecs[4]  = '{{5'd7,5'd7}, RF_A, 5'd7, 1'b1, 32'h7777, 5'd7, 1'b1, 32'h8888, 1'b0, 10'd0, 2'b00, 5'd0, 1'b0, 1'b0, 4'b0101, {32'h0000_7777, 32'h0000_7777}, 1'b0};
    vecs[5]  = '{{5'd7,5'd7}, RF_A, 5'd3, 1'b1, 32'h7777, 5'd7, 1'b0, 32'h8888, 1'b0, 10'd0, 2'b00, 5'd0, 1'b0, 1'b0, 4'b0000, RF_A, 1'b0};
    vecs[6]  = '{10'd0, RF_A, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, {5'd7,5'd2}, 2'b11, 5'd7, 1'b1, 1'b1, 4'b0000, RF_A, 1'b1};
    vecs[7]  = '{10'd0, RF_A, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, {5'd7,5'd2}, 2'b01, 5'd7, 1'b1, 1'b1, 4'b0000, RF_A, 1'b0};
    vecs[8]  = '{10'd0, RF_A, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, {5'd7,5'd2}, 2'b11, 5'd7, 1'b1, 1'b0, 4'b0000, RF_A, 1'b0};
    vecs[9]  = '{10'd0, RF_A, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, {5'd0,5'd0}, 2'b11, 5'd0, 1'b1, 1'b1, 4'b0000, RF_A, 1'b0};
    vecs[10] = '{10'd0, RF_A, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, {5'd7,5'd2}, 2'b11, 5'd7, 1'b1, 1'b1, 4'b0000, RF_A, 1'b0};
    vecs[11] = '{10'd0, RF_A, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, {5'd1,5'd7}, 2'b01, 5'd7, 1'b1, 1'b1, 4'b0000, RF_A, 1'b1};
    vecs[12] = '{10'd0, RF_A, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, {5'd1,5'd7}, 2'b01, 5'd7, 1'b0, 1'b1, 4'b0000, RF_A, 1'b0};

    // Reset state
    do_reset();
    check_md("reset", 1'b0, 1'b0, 5'd0);
    checkOutput("reset stall_cnt", 64'(bus.stall_cnt_o), 64'd0);
    checkOutput("reset stall", 64'(bus.stall_o), 64'd0);

    // Combinational forwarding and load-use table
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive_idle();
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d fwd_sel", i), 64'(bus.fwd_sel_o), 64'(vecs[i].exp_sel));
      checkOutput($sformatf("vec%0d ex_rs_data", i), bus.ex_rs_data_o, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d stall", i), 64'(bus.stall_o), 64'(vecs[i].exp_stall));
    end

    // Load-use stall lasts one cycle and is counted once
    do_reset();
    @(negedge clk);
    bus.id_valid_i = 1'b1; bus.id_rs_addr_i = {5'd7, 5'd2}; bus.id_rs_used_i = 2'b10;
    bus.id_ex_rd_addr_i = 5'd7; bus.id_ex_rd_wena_i = 1'b1; bus.id_ex_is_load_i = 1'b1;
    #1;
    checkOutput("lu stall", 64'(bus.stall_o), 64'd1);
    @(negedge clk);
    bus.id_ex_rd_wena_i = 1'b0; bus.id_ex_is_load_i = 1'b0; bus.id_ex_rd_addr_i = 5'd0;
    #1;
    checkOutput("lu bubble stall", 64'(bus.stall_o), 64'd0);
    checkOutput("lu stall_cnt", 64'(bus.stall_cnt_o), 64'd1);
    @(negedge clk);
    bus.id_rs_used_i = 2'b01; bus.id_ex_rd_addr_i = 5'd7; bus.id_ex_rd_wena_i = 1'b1; bus.id_ex_is_load_i = 1'b1;
    #1;
    checkOutput("lu unused stall", 64'(bus.stall_o), 64'd0);

    // MD issue rd=3, dependent reader stalls through the done cycle
    do_reset();
    @(negedge clk);
    bus.id_valid_i = 1'b1; bus.id_is_md_i = 1'b1; bus.id_rd_addr_i = 5'd3; bus.id_rd_wena_i = 1'b1;
    #1;
    checkOutput("md issue stall", 64'(bus.stall_o), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive_idle();
      bus.id_valid_i = 1'b1; bus.id_rs_addr_i = {5'd0, 5'd3}; bus.id_rs_used_i = 2'b01;
      bus.flush_i = (k == 2);
      #1;
      check_md($sformatf("raw k%0d", k), k <= 4, k == 4, (k <= 4) ? 5'd3 : 5'd3);
      checkOutput($sformatf("raw k%0d stall", k), 64'(bus.stall_o), 64'(k <= 4));
      checkOutput($sformatf("raw k%0d stall_cnt", k), 64'(bus.stall_cnt_o), 64'(k - 1));
    end

    // Back-to-back MD: structural stall, issue at T+5, then WAW check
    do_reset();
    @(negedge clk);
    bus.id_valid_i = 1'b1; bus.id_is_md_i = 1'b1; bus.id_rd_addr_i = 5'd3; bus.id_rd_wena_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.id_rd_addr_i = 5'd10;
      #1;
      checkOutput($sformatf("md2 k%0d stall", k), 64'(bus.stall_o), 64'(k <= 4));
    end
    @(negedge clk);
    drive_idle();
    #1;
    check_md("md2 issued", 1'b1, 1'b0, 5'd10);
    checkOutput("md2 stall_cnt", 64'(bus.stall_cnt_o), 64'd4);
    @(negedge clk);
    bus.id_valid_i = 1'b1; bus.id_rd_addr_i = 5'd10; bus.id_rd_wena_i = 1'b1;
    #1;
    checkOutput("waw stall", 64'(bus.stall_o), 64'd1);
    @(negedge clk);
    bus.id_rd_wena_i = 1'b0;
    #1;
    checkOutput("waw no-wena stall", 64'(bus.stall_o), 64'd0);

    // Flush on the issue cycle blocks the issue
    do_reset();
    @(negedge clk);
    bus.id_valid_i = 1'b1; bus.id_is_md_i = 1'b1; bus.id_rd_addr_i = 5'd5; bus.id_rd_wena_i = 1'b1; bus.flush_i = 1'b1;
    #1;
    @(negedge clk);
    drive_idle();
    #1;
    check_md("flush", 1'b0, 1'b0, 5'd0);

    // Reset during an MD op: no done pulse afterwards, stall/fwd gated in reset
    do_reset();
    @(negedge clk);
    bus.id_valid_i = 1'b1; bus.id_is_md_i = 1'b1; bus.id_rd_addr_i = 5'd3; bus.id_rd_wena_i = 1'b1;
    @(negedge clk);
    drive_idle();
    #1;
    checkOutput("rstmd busy T+1", 64'(bus.md_busy_o), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.id_valid_i = 1'b1; bus.id_is_md_i = 1'b1;
    bus.ex_rs_addr_i = {5'd9, 5'd9}; bus.ex_mem_rd_addr_i = 5'd9; bus.ex_mem_rd_wena_i = 1'b1;
    #1;
    checkOutput("rst stall gated", 64'(bus.stall_o), 64'd0);
    checkOutput("rst fwd_sel gated", 64'(bus.fwd_sel_o), 64'd0);
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
      #1;
      check_md($sformatf("rstmd T+%0d", k), 1'b0, 1'b0, 5'd0);
    end

    // Stall counter saturation
    do_reset();
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      bus.id_valid_i = 1'b1; bus.id_rs_addr_i = {5'd0, 5'd7}; bus.id_rs_used_i = 2'b01;
      bus.id_ex_rd_addr_i = 5'd7; bus.id_ex_rd_wena_i = 1'b1; bus.id_ex_is_load_i = 1'b1;
      #1;
      checkOutput($sformatf("sat k%0d stall_cnt", k), 64'(bus.stall_cnt_o), 64'((k > 15) ? 15 : k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Parametrised successor to the EX-stage forwarding/hazard logic of the 5-stage RISC-V pipeline. Sits between ID/EX and the EX datapath.
- Generalises forwarding to NRD read ports and resolves load-use hazards.
- Adds a scoreboard/countdown for one fixed-latency multi-cycle mul/div (MD) unit.
- Adds a saturating stall performance counter.

Parameters:
XLEN, 32, data width
AW, 5, register address width
NRD, 2, number of source-operand ports (ports 0..NRD-1, packed LSB-first)
MD_LAT, 4, MD unit latency in cycles (>=2)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid_i  in  1  ID holds a valid instruction
id_rs_addr_i  in  NRD*AW  ID source register addresses
id_rs_used_i  in  NRD  ID source port is read
id_rd_addr_i  in  AW  ID destination register
id_rd_wena_i  in  1  ID instruction writes rd
id_is_md_i  in  1  ID instruction is an MD op
flush_i  in  1  kill the ID instruction this cycle
id_ex_rd_addr_i  in  AW  ID/EX destination register
id_ex_rd_wena_i  in  1  ID/EX writes rd
id_ex_is_load_i  in  1  ID/EX instruction is a load
ex_rs_addr_i  in  NRD*AW  EX source register addresses
ex_rs_data_i  in  NRD*XLEN  EX operands from the register file
ex_mem_rd_addr_i  in  AW  EX/MEM rd
ex_mem_rd_wena_i  in  1  EX/MEM writes rd
ex_mem_data_i  in  XLEN  EX/MEM result
mem_wb_rd_addr_i  in  AW  MEM/WB rd
mem_wb_rd_wena_i  in  1  MEM/WB writes rd
mem_wb_data_i  in  XLEN  MEM/WB result
ex_rs_data_o  out  NRD*XLEN  forwarded EX operands
fwd_sel_o  out  NRD*2  per-port select: 00 regfile, 01 EX/MEM, 10 MEM/WB
stall_o  out  1  hold PC/IF/ID, insert bubble into ID/EX
md_busy_o  out  1  MD operation in flight
md_done_o  out  1  one-cycle pulse: MD result written back this cycle
md_rd_o  out  AW  destination of the in-flight MD op
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=1 at a clk edge): md_busy_o=0, md_done_o=0, md_rd_o=0, stall_cnt_o=0, internal countdown=0.
  - While rst=1, stall_o=0 and fwd_sel_o=0.
- Forwarding (combinational, per port p):
  - Select EX/MEM if ex_mem_rd_wena_i, ex_mem_rd_addr_i != 0, and the address equals ex_rs_addr_i[p].
  - Otherwise select MEM/WB under the same conditions on the MEM/WB inputs.
  - Otherwise select the register file.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Load-use hazard: raise stall_o when id_valid_i, id_ex_is_load_i, id_ex_rd_wena_i, id_ex_rd_addr_i != 0, and any used ID source port matches id_ex_rd_addr_i. Lasts exactly one cycle.
- MD issue: occurs when id_valid_i & id_is_md_i & !stall_o & !flush_i. At the issue edge:
  - countdown loads MD_LAT;
  - md_rd_o latches id_rd_addr_i, or 0 if !id_rd_wena_i.
- MD timing for an issue in cycle T:
  - md_busy_o=1 for cycles T+1..T+MD_LAT;
  - md_done_o=1 in cycle T+MD_LAT only;
  - md_busy_o=0 in cycle T+MD_LAT+1.
- MD hazards: while md_busy_o, stall_o=1 if id_valid_i and any of the following holds:
  - a used source equals md_rd_o != 0 (RAW);
  - id_rd_wena_i and id_rd_addr_i equals md_rd_o != 0 (WAW);
  - id_is_md_i (structural).
  - These stalls include the md_done_o cycle, so the earliest back-to-back MD issue is cycle T+MD_LAT+1.
- stall_o is the OR of the load-use and MD hazards, and is gated by id_valid_i.
  - flush_i does not suppress stall_o.
  - flush_i blocks issue only; an in-flight MD op always completes.
- stall_cnt_o increments on every cycle with stall_o=1. It saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-MD: busy is cleared and no md_done_o pulse is produced.

Decomposition:
- Shared package/define header holds:
  - fwd select encodings FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - default XLEN/AW.
- One sub-module, fwd_mux_port, instanced NRD times. It is the per-port comparator plus 3:1 operand mux and produces one fwd_sel and one data word.

Test Plan:
- Reset, then ex_rs_addr_i[0]=5, ex_mem rd=5 wena=1 data=0xAAAA, mem_wb rd=5 data=0xBBBB -> fwd_sel[0]=01, operand 0xAAAA. Drop ex_mem wena -> 10, 0xBBBB.
- ex_rs_addr_i[1]=0 with ex_mem rd=0 wena=1 -> fwd_sel[1]=00, regfile data passed unchanged.
- id_ex load rd=7; ID uses rs2=7 -> stall_o=1 for one cycle and stall_cnt_o=1. Same with rs2 unused -> no stall.
- MD issue rd=3 at cycle T, MD_LAT=4 -> md_busy_o high T+1..T+4, md_done_o only at T+4. ID reading x3 at T+1 stalls through T+4 and proceeds at T+5 (stall_cnt_o=4).
- Second MD op presented at T+1 -> stalls until T+4 and issues at T+5. flush_i at the issue cycle -> no issue and md_busy_o stays 0.
- rst asserted at T+2 of an MD op -> md_busy_o=0 next cycle and no md_done_o pulse. Preload near-max count (CNT_W=4, 16 stalls) -> stall_cnt_o holds at 15.
